// File: rtl/dram_read_cache.sv
// Direct-mapped, write-through, write-allocate read cache with one-word lines
// in front of an external DRAM controller (req/ack handshake).
module dram_read_cache #(
    parameter int unsigned INDEX_BITS = 10,
    parameter int unsigned ADDR_W     = 27
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] addr_dram,
    input  logic [31:0]       din_dram,
    input  logic              rw_dram,
    input  logic              valid_dram,
    output logic [31:0]       dout_dram,
    output logic              ready_dram,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned TAG_W  = ADDR_W - INDEX_BITS - 2;
    localparam int unsigned LINE_W = TAG_W + DATA_W;
    localparam int unsigned LINES  = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM    = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   req_word;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_rw;
    logic [LINES-1:0]    valid_bits;

    logic [LINE_W-1:0]   line_ram [LINES];
    logic [LINE_W-1:0]   rd_line;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] in_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  hit;
    logic                  ram_re;
    logic                  ram_we;
    logic [LINE_W-1:0]     ram_wline;
    logic                  unused_lsbs;

    // Byte-lane bits of the request address carry no meaning for word lines.
    assign unused_lsbs = ^addr_dram[1:0];

    assign req_idx               = req_word[INDEX_BITS-1:0];
    assign req_tag               = req_word[WORD_W-1:INDEX_BITS];
    assign in_idx                = addr_dram[INDEX_BITS+1:2];
    assign {line_tag, line_data} = rd_line;

    // Array access: read at request acceptance, write on write-allocate or read fill.
    always_comb begin
        hit       = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wline = '0;
        hit       = valid_bits[req_idx] && (line_tag == req_tag);
        ram_re    = (state == IDLE) && valid_dram;
        ram_we    = ((state == LOOKUP) && req_rw) ||
                    ((state == MEM) && mem_ack && !req_rw);
        ram_wline = {req_tag, (req_rw ? req_wdata : mem_rdata)};
    end

    // Tag/data storage: synchronous-read RAM, deliberately without reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            line_ram[req_idx] <= ram_wline;
        end
        if (ram_re) begin
            rd_line <= line_ram[in_idx];
        end
    end

    // Control FSM, registered outputs, line valid bits and saturating counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_word   <= '0;
            req_wdata  <= '0;
            req_rw     <= 1'b0;
            valid_bits <= '0;
            dout_dram  <= '0;
            ready_dram <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_req    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            ready_dram <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_dram) begin
                        req_word  <= addr_dram[ADDR_W-1:2];
                        req_wdata <= din_dram;
                        req_rw    <= rw_dram;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_rw) begin
                        valid_bits[req_idx] <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_word, 2'b00};
                        mem_wdata <= req_wdata;
                        state     <= MEM;
                    end else if (hit) begin
                        dout_dram <= line_data;
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 32'd1;
                        end
                        ready_dram <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_word, 2'b00};
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 32'd1;
                        end
                        state <= MEM;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!req_rw) begin
                            valid_bits[req_idx] <= 1'b1;
                            dout_dram <= mem_rdata;
                        end
                        ready_dram <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dram_read_cache.md
Name: dram_read_cache

Overview:
- Direct-mapped, write-through, write-allocate cache with one-word lines, sitting directly downstream of the data memory block's DRAM port.
- Consumes addr_dram/din_dram/rw_dram/valid_dram and returns dout_dram/ready_dram.
- Forwards misses and all writes to the external DRAM controller over a req/ack interface.
- Hides DRAM latency for repeated loads of heap/stack data above the on-chip BRAM region.

Parameters:
INDEX_BITS, 10, log2 of line count; index = addr[INDEX_BITS+1:2]
ADDR_W, 27, byte address width; tag = addr[ADDR_W-1:INDEX_BITS+2]

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
addr_dram  in  27  byte address of request; [1:0] ignored
din_dram  in  32  write data
rw_dram  in  1  1 = write, 0 = read
valid_dram  in  1  request present; held stable by upstream until ready_dram
dout_dram  out  32  read data, meaningful while ready_dram = 1
ready_dram  out  1  one-cycle completion pulse
mem_addr  out  27  word-aligned address to DRAM controller ([1:0] = 0)
mem_wdata  out  32  write data to controller
mem_we  out  1  1 = write transaction
mem_req  out  1  transaction request, level, held until mem_ack
mem_ack  in  1  one-cycle completion from controller
mem_rdata  in  32  read data, valid with mem_ack when mem_we = 0
hit_count  out  32  read hits since reset, saturating at 0xFFFFFFFF
miss_count  out  32  read misses since reset, saturating

Behaviour:
- Reset values (asynchronous, immediate on rstn low):
  - dout_dram = 0, ready_dram = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Counters = 0. All line valid bits = 0. FSM = IDLE.
- Storage:
  - Valid bits are a 2^INDEX_BITS register vector with async reset.
  - Tag and data live in a synchronous-read inferred RAM with no reset.
- IDLE:
  - When valid_dram = 1, latch addr, din and rw, issue the array read at the index, and go to LOOKUP.
  - Input changes after latching are ignored until RESP.
- LOOKUP: hit = valid bit set and stored tag equals latched tag.
  - Read hit: dout_dram <= line data, hit_count++, go to RESP.
  - Read miss: mem_req <= 1, mem_we <= 0, mem_addr <= {addr[26:2], 2'b00}, miss_count++, go to MEM.
  - Write (hit or miss):
    - Write tag and data into the line and set the valid bit.
    - mem_req <= 1, mem_we <= 1, mem_wdata <= din, go to MEM.
    - Writes do not touch the counters.
- MEM:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant until mem_ack.
  - On mem_ack: mem_req <= 0, go to RESP.
  - If the transaction is a read, also fill the line (tag, data, valid) with mem_rdata and set dout_dram <= mem_rdata.
  - mem_ack outside MEM is ignored.
- RESP:
  - ready_dram = 1 for exactly this cycle, then go to IDLE.
  - dout_dram holds its value until the next read completes.
- Latency:
  - Read hit: ready_dram 2 cycles after the valid_dram sample edge.
  - Miss or write: ready_dram 1 cycle after the mem_ack cycle.
- Back-to-back requests:
  - IDLE samples valid_dram the cycle after RESP.
  - A still-high valid_dram there is a new request and counts as one.
- At most one outstanding DRAM transaction at any time.
- Reset mid-MEM:
  - mem_req drops immediately, and any later mem_ack is ignored.
  - The controller must tolerate an abandoned request.
- Counter saturation: at 0xFFFFFFFF the counter holds; no wrap.
- Aliasing: addresses differing only in tag map to the same line; the newest access replaces the line.

Test Plan:
- Reset, then read 0x0004000:
  - Expect mem_req = 1, mem_addr = 0x0004000, mem_we = 0.
  - Ack after 5 cycles with mem_rdata = 0xDEADBEEF.
  - Expect ready_dram for one cycle, dout = 0xDEADBEEF, miss_count = 1.
- Read 0x0004000 again:
  - Expect no mem_req, ready_dram 2 cycles after valid, dout = 0xDEADBEEF, hit_count = 1.
- Write 0x0004000 with 0x12345678:
  - Expect mem_req with mem_we = 1 and mem_wdata = 0x12345678, then ready_dram after ack.
  - Following read hits and returns 0x12345678; miss_count unchanged.
- Conflict at INDEX_BITS = 10: read 0x0004000, read 0x0005000, then read 0x0004000.
  - Both later reads miss; mem_addr matches each request; miss_count += 2.
- Assert rstn low while in MEM:
  - Expect mem_req, ready_dram and the counters to go to 0 in the same cycle.
  - After release, a read of 0x0004000 misses.
  - A stray mem_ack during IDLE produces no ready_dram.
- Hold valid_dram high through RESP with a hit address:
  - Expect a second ready_dram pulse 3 cycles after the first, and hit_count incremented twice.
- Force hit_count to 0xFFFFFFFF (preload via forced state), then perform a read hit:
  - Expect it to remain 0xFFFFFFFF.
